rr_arbiter4: RTL and testbench

- 4-requester round-robin arbiter sharing one downstream resource (bus/port) between requesters i0..i3.
- Arbitration uses a rotating-priority 4-bit priority encoder: rotate request vector by pointer, encode, rotate index back.
- Holds a grant until the owner signals done, drops its request, or a hold timeout expires.
- Sits in front of any shared datapath block; downstream muxes select on gnt_id.

---
 rtl/rr_arbiter4_pkg.sv | 19 +
 rtl/rr_arbiter4_if.sv | 23 ++
 rtl/rr_arbiter4_prienc4_rot.sv | 35 +++
 rtl/rr_arbiter4.sv | 115 +++++++++++
 tb/tb_rr_arbiter4.sv | 137 +++++++++++++
 5 files changed

// File: rtl/rr_arbiter4_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package rr_arbiter4_pkg;

   localparam int unsigned N_REQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // Binary requester index to one-hot grant vector.
   function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// slave = arbiter side (serves requests), master = requester side.
interface rr_arbiter4_if;
   import rr_arbiter4_pkg::*;

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] gnt;
   logic [1:0]       gnt_id;
   logic             gnt_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  req, done,
      output gnt, gnt_id, gnt_valid, timeout
   );

endinterface

// File: rtl/rr_arbiter4_prienc4_rot.sv
// Rotating-priority encoder: the first set request bit scanning i_ptr, i_ptr+1, ... (mod 4)
// wins. Rotate the request down by i_ptr, take the lowest set bit, rotate the index back.
module prienc4_rot
   import rr_arbiter4_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [1:0]       i_ptr,
   output logic [1:0]       o_idx,
   output logic             o_any
);

   logic [N_REQ-1:0] w_rot;
   logic [1:0]       w_src;
   logic [1:0]       w_enc;

   // Rotate, encode lowest set bit, unrotate.
   always_comb begin
      w_rot = '0;
      w_src = '0;
      w_enc = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_src    = 2'(i) + i_ptr;
         w_rot[i] = i_req[w_src];
      end
      // Scan downward so the lowest set bit is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_enc = 2'(i);
         end
      end
      o_any = |w_rot;
      o_idx = w_enc + i_ptr;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter. A grant is held until the owner signals done, drops its
// request, or holds it for MAX_HOLD cycles; on release the owner drops to lowest priority and
// arbitration happens in the same edge so back-to-back grants have no idle bubble.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,  // 2..255
   parameter int unsigned CW       = 8    // 2**CW > MAX_HOLD
) (
   input  logic         clk,
   input  logic         rst,
   rr_arbiter4_if.slave arb
);

   localparam logic [CW-1:0] MAX_HOLD_CNT = CW'(MAX_HOLD);

   state_e           r_state,  w_state_d;
   logic [1:0]       r_ptr,    w_ptr_d;
   logic [CW-1:0]    r_cnt,    w_cnt_d;
   logic [N_REQ-1:0] r_gnt,    w_gnt_d;
   logic [1:0]       r_gnt_id, w_gnt_id_d;
   logic             r_timeout, w_timeout_d;

   logic [1:0]       w_arb_ptr;
   logic [1:0]       w_win_idx;
   logic             w_win_any;
   logic             w_owner_req;
   logic             w_at_limit;
   logic             w_release;

   // While granted, arbitrate as if the owner were already released so the new pointer
   // takes effect in the release edge itself.
   always_comb begin
      w_arb_ptr = (r_state == ST_GRANT) ? r_gnt_id + 2'd1 : r_ptr;
   end

   prienc4_rot u_prienc (
      .i_req (arb.req),
      .i_ptr (w_arb_ptr),
      .o_idx (w_win_idx),
      .o_any (w_win_any)
   );

   // Next-state, pointer, hold counter and grant outputs.
   always_comb begin
      w_state_d   = r_state;
      w_ptr_d     = r_ptr;
      w_cnt_d     = r_cnt;
      w_gnt_d     = r_gnt;
      w_gnt_id_d  = r_gnt_id;
      w_timeout_d = 1'b0;

      w_owner_req = arb.req[r_gnt_id];
      w_at_limit  = (r_cnt == MAX_HOLD_CNT);
      w_release   = arb.done | ~w_owner_req | w_at_limit;

      unique case (r_state)
         ST_IDLE: begin
            if (w_win_any) begin
               w_state_d  = ST_GRANT;
               w_gnt_d    = onehot4(w_win_idx);
               w_gnt_id_d = w_win_idx;
               w_cnt_d    = CW'(1);
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               // Timeout is reported only when done and abandon did not already release.
               w_timeout_d = ~arb.done & w_owner_req & w_at_limit;
               w_ptr_d     = r_gnt_id + 2'd1;
               if (w_win_any) begin
                  w_gnt_d    = onehot4(w_win_idx);
                  w_gnt_id_d = w_win_idx;
                  w_cnt_d    = CW'(1);
               end else begin
                  w_state_d = ST_IDLE;
                  w_gnt_d   = '0;
                  w_cnt_d   = '0;
               end
            end else if (r_cnt != MAX_HOLD_CNT) begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_d = ST_IDLE;
            w_gnt_d   = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_ptr     <= w_ptr_d;
         r_cnt     <= w_cnt_d;
         r_gnt     <= w_gnt_d;
         r_gnt_id  <= w_gnt_id_d;
         r_timeout <= w_timeout_d;
      end
   end

   assign arb.gnt       = r_gnt;
   assign arb.gnt_id    = r_gnt_id;
   assign arb.gnt_valid = |r_gnt;
   assign arb.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, single grant, fairness, wrap-around, timeout,
// abandon, done-vs-timeout priority and reset mid-grant.
module tb_rr_arbiter4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   rr_arbiter4_if u_if ();

   rr_arbiter4 #(
      .MAX_HOLD (16),
      .CW       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .arb (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input string tag, input logic [3:0] gnt, input logic [1:0] id,
                               input logic valid, input logic to);
      check_eq({tag, ".gnt"}, 32'(u_if.gnt), 32'(gnt));
      if (valid) check_eq({tag, ".gnt_id"}, 32'(u_if.gnt_id), 32'(id));
      check_eq({tag, ".gnt_valid"}, 32'(u_if.gnt_valid), 32'(valid));
      check_eq({tag, ".timeout"}, 32'(u_if.timeout), 32'(to));
   endtask

   initial begin
      logic [1:0] order [5];
      order    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      n_checks = 0;
      n_fail   = 0;

      // Reset for two cycles.
      rst = 1'b1; u_if.req = 4'b0000; u_if.done = 1'b0;
      tick(); tick();
      expect_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_eq("reset.gnt_id", 32'(u_if.gnt_id), 32'd0);
      rst = 1'b0;

      // Single request, then release with done; ptr becomes 3.
      u_if.req = 4'b0100;
      tick();
      expect_grant("single", 4'b0100, 2'd2, 1'b1, 1'b0);
      u_if.req = 4'b0000; u_if.done = 1'b1;
      tick();
      expect_grant("single_done", 4'b0000, 2'd0, 1'b0, 1'b0);
      u_if.done = 1'b0; u_if.req = 4'b1111;
      tick();
      expect_grant("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);

      // Fairness: done every cycle with all requesting.
      u_if.done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         expect_grant($sformatf("rr%0d", k), 4'b0001 << order[k], order[k], 1'b1, 1'b0);
      end
      u_if.req = 4'b0000;
      tick();
      expect_grant("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Wrap-around: after owner 3 releases, requester 0 beats requester 3.
      u_if.done = 1'b0; u_if.req = 4'b1000;
      tick();
      expect_grant("wrap3", 4'b1000, 2'd3, 1'b1, 1'b0);
      u_if.done = 1'b1; u_if.req = 4'b1001;
      tick();
      expect_grant("wrap0", 4'b0001, 2'd0, 1'b1, 1'b0);
      u_if.req = 4'b0000;
      tick();
      expect_grant("wrap_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Timeout: held for 16 cycles, pulse on revoke, sole requester regranted.
      u_if.done = 1'b0; u_if.req = 4'b0010;
      tick();
      expect_grant("to_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
      for (int i = 2; i <= 16; i++) begin
         tick();
         expect_grant($sformatf("to_c%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      tick();
      expect_grant("to_fire", 4'b0010, 2'd1, 1'b1, 1'b1);
      tick();
      expect_grant("to_after", 4'b0010, 2'd1, 1'b1, 1'b0);

      // Abandon: owner 2 drops request, requester 0 takes over in the same edge.
      u_if.done = 1'b1; u_if.req = 4'b0100;
      tick();
      expect_grant("ab_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      u_if.done = 1'b0; u_if.req = 4'b0001;
      tick();
      expect_grant("ab_move", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Done together with cnt==MAX_HOLD: no timeout pulse.
      for (int i = 2; i <= 16; i++) tick();
      check_eq("dt_hold.timeout", 32'(u_if.timeout), 32'd0);
      u_if.done = 1'b1;
      tick();
      expect_grant("dt_done", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Reset mid-grant with ptr=3; afterwards requester 1 wins over 3.
      u_if.req = 4'b0100;
      tick();
      expect_grant("mr_own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      u_if.req = 4'b1000;
      tick();
      expect_grant("mr_own3", 4'b1000, 2'd3, 1'b1, 1'b0);
      u_if.done = 1'b0; u_if.req = 4'b1010; rst = 1'b1;
      tick();
      expect_grant("mr_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      check_eq("mr_reset.gnt_id", 32'(u_if.gnt_id), 32'd0);
      rst = 1'b0;
      tick();
      expect_grant("mr_after", 4'b0010, 2'd1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
